// File: rtl/inst_loader_pkg.sv
// Shared loader definitions: state encoding, stream framing constants and the header length check.
package inst_loader_pkg;

    localparam int BYTES_PER_INST = 4;
    localparam int LDR_HDR_BYTES  = 2;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_HDR0  = 3'd1,
        LDR_HDR1  = 3'd2,
        LDR_DATA  = 3'd3,
        LDR_WRITE = 3'd4,
        LDR_DONE  = 3'd5
    } ldr_state_e;

    // A load may fill the RAM exactly but never exceed its depth.
    function automatic logic ldr_len_too_long(input logic [15:0] len, input int unsigned addr_width);
        logic [16:0] depth;
        depth = 17'd1 << addr_width;
        return {1'b0, len} > depth;
    endfunction

endpackage

// File: rtl/inst_loader_word_assembler.sv
// Collects four stream bytes into a little-endian instruction word.
module ldr_word_assembler
    import inst_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_i,
    input  logic                          byte_valid_i,
    input  logic [7:0]                    byte_i,
    output logic [8*BYTES_PER_INST-1:0]   word_o,
    output logic                          word_ready_o
);

    localparam int IDX_W = $clog2(BYTES_PER_INST);

    logic [IDX_W-1:0]              byte_idx_q;
    logic [8*BYTES_PER_INST-1:0]   word_q;

    // The word completes on the byte that lands in the top lane.
    assign word_ready_o = byte_valid_i && (byte_idx_q == IDX_W'(BYTES_PER_INST - 1));
    assign word_o       = word_q;

    // Byte lane index and word register; the index wraps to 0 after the top lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q <= {IDX_W{1'b0}};
            word_q     <= {(8*BYTES_PER_INST){1'b0}};
        end else if (clr_i) begin
            byte_idx_q <= {IDX_W{1'b0}};
        end else if (byte_valid_i) begin
            byte_idx_q                <= byte_idx_q + IDX_W'(1);
            word_q[8*byte_idx_q +: 8] <= byte_i;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Streams a length-prefixed byte image into instruction RAM from word 0, holding the core until it completes.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int INST_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    s_valid_i,
    input  logic [7:0]              s_data_i,
    output logic                    s_ready_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [INST_WIDTH-1:0]   mem_din_o,
    output logic                    cpu_hold_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_len_o,
    output logic [ADDR_WIDTH:0]     words_written_o
);

    ldr_state_e                state_q, state_d;
    logic [7:0]                len_lo_q, len_lo_d;
    logic [ADDR_WIDTH:0]       wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH:0]       remaining_q, remaining_d;
    logic [ADDR_WIDTH:0]       words_q, words_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      hold_q, hold_d;
    logic                      busy_q, busy_d;
    logic                      rdy_q, rdy_d;
    logic                      we_q, we_d;

    logic                      acc_s;
    logic                      word_ready_s;
    logic [15:0]               len_s;
    logic [INST_WIDTH-1:0]     asm_word_s;

    assign acc_s = s_valid_i && rdy_q;
    assign len_s = {s_data_i, len_lo_q};

    ldr_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (state_q == LDR_HDR1),
        .byte_valid_i (acc_s && (state_q == LDR_DATA)),
        .byte_i       (s_data_i),
        .word_o       (asm_word_s),
        .word_ready_o (word_ready_s)
    );

    // Next state, counters and status; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        wr_addr_d   = wr_addr_q;
        remaining_d = remaining_q;
        words_d     = words_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            LDR_IDLE, LDR_DONE: begin
                if (start_i) begin
                    state_d = LDR_HDR0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = {(ADDR_WIDTH+1){1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            LDR_HDR0: begin
                if (acc_s) begin
                    len_lo_d = s_data_i;
                    state_d  = LDR_HDR1;
                end else begin
                    state_d = LDR_HDR0;
                end
            end
            LDR_HDR1: begin
                if (!acc_s) begin
                    state_d = LDR_HDR1;
                end else if (len_s == 16'd0) begin
                    state_d = LDR_DONE;
                    done_d  = 1'b1;
                end else if (ldr_len_too_long(len_s, ADDR_WIDTH)) begin
                    state_d = LDR_DONE;
                    err_d   = 1'b1;
                end else begin
                    remaining_d = len_s[ADDR_WIDTH:0];
                    wr_addr_d   = {(ADDR_WIDTH+1){1'b0}};
                    state_d     = LDR_DATA;
                end
            end
            LDR_DATA: begin
                if (word_ready_s) begin
                    state_d = LDR_WRITE;
                end else begin
                    state_d = LDR_DATA;
                end
            end
            LDR_WRITE: begin
                wr_addr_d   = wr_addr_q + (ADDR_WIDTH+1)'(1);
                remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                words_d     = words_q + (ADDR_WIDTH+1)'(1);
                if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                    state_d = LDR_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = LDR_DATA;
                end
            end
            default: begin
                state_d = LDR_IDLE;
            end
        endcase

        rdy_d  = state_d inside {LDR_HDR0, LDR_HDR1, LDR_DATA};
        busy_d = state_d inside {LDR_HDR0, LDR_HDR1, LDR_DATA, LDR_WRITE};
        we_d   = (state_d == LDR_WRITE);
        addr_d = we_d ? wr_addr_d[ADDR_WIDTH-1:0] : addr_q;
        // The core only runs from a successfully loaded image.
        hold_d = !((state_d == LDR_DONE) && !err_d);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LDR_IDLE;
            len_lo_q    <= 8'd0;
            wr_addr_q   <= {(ADDR_WIDTH+1){1'b0}};
            remaining_q <= {(ADDR_WIDTH+1){1'b0}};
            words_q     <= {(ADDR_WIDTH+1){1'b0}};
            addr_q      <= {ADDR_WIDTH{1'b0}};
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= 1'b1;
            busy_q      <= 1'b0;
            rdy_q       <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            wr_addr_q   <= wr_addr_d;
            remaining_q <= remaining_d;
            words_q     <= words_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            rdy_q       <= rdy_d;
            we_q        <= we_d;
        end
    end

    assign s_ready_o       = rdy_q;
    assign mem_en_o        = we_q;
    assign mem_we_o        = we_q;
    assign mem_addr_o      = addr_q;
    assign mem_din_o       = asm_word_s;
    assign cpu_hold_o      = hold_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_len_o       = err_q;
    assign words_written_o = words_q;

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Write-side counterpart of the fetch stage's instruction-RAM read port.
- Receives a byte stream over a valid/ready interface, typically from a UART receiver. Assembles little-endian 32-bit instruction words and writes them into the instruction RAM at consecutive word addresses starting from 0.
- Holds the core (PC enable low, fetch in reset) while loading, then releases it so fetch starts at PC 0.

Parameters:
- ADDR_WIDTH, 10, word-address width of instruction RAM; depth = 2^ADDR_WIDTH words.
- INST_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_ready  out  1  loader can accept a byte.
- mem_en  out  1  instruction RAM port enable.
- mem_we  out  1  instruction RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM word address.
- mem_din  out  INST_WIDTH  RAM write data.
- cpu_hold  out  1  high = core held: fetch PC enable forced low, fetch and RAM output reset asserted.
- busy  out  1  load in progress.
- done  out  1  last load finished successfully (level).
- err_len  out  1  last header was rejected (level).
- words_written  out  ADDR_WIDTH+1  words written in current/last load.

Behaviour:
- Reset values:
  - State IDLE.
  - s_ready, mem_en, mem_we, busy, done and err_len = 0.
  - mem_addr, mem_din and words_written = 0.
  - cpu_hold = 1.
- Holding the core from reset to first DONE prevents fetch from running uninitialised RAM.
- A byte is accepted only on a cycle where s_valid && s_ready.
- s_valid without s_ready is ignored; the byte is not consumed.
- FSM states: IDLE, HDR0, HDR1, DATA, WRITE, DONE.
- IDLE:
  - cpu_hold=1.
  - start -> HDR0; clears done, err_len and words_written.
- HDR0:
  - s_ready=1, busy=1.
  - Accepted byte -> len[7:0]; go to HDR1.
- HDR1:
  - s_ready=1.
  - Accepted byte -> len[15:8]. Next state depends on the assembled 16-bit len:
    - len == 0 -> DONE, nothing written.
    - len > 2^ADDR_WIDTH -> err_len=1, go to DONE with done=0; nothing written, RAM untouched.
    - Otherwise remaining=len, wr_addr=0, byte_idx=0, go to DATA.
- DATA:
  - s_ready=1.
  - Accepted byte is placed at word[8*byte_idx +: 8] (little-endian); byte_idx increments.
  - On the 4th byte (byte_idx==3) -> WRITE.
- WRITE (exactly one cycle):
  - s_ready=0.
  - mem_en=1, mem_we=1, mem_addr=wr_addr, mem_din=assembled word.
  - Next cycle: wr_addr+1, remaining-1, words_written+1, byte_idx=0.
  - Then -> DONE if remaining was 1, else DATA.
- Timing:
  - mem_en/mem_we are registered outputs, high only during WRITE.
  - Write latency from acceptance of a word's 4th byte to mem_we high is exactly 1 cycle.
  - Peak throughput: 1 byte/cycle with a 1-cycle bubble per word.
- DONE:
  - done=1 only if err_len=0.
  - busy=0, s_ready=0.
  - cpu_hold=0 after a successful load; stays 1 after an error.
  - start -> HDR0 for a reload. cpu_hold rises in the same cycle the state leaves DONE, before any write.
- start while busy is ignored.
- Extra stream bytes after the last word are not accepted (s_ready=0).
- Address wrap: not possible, because len ≤ depth is enforced. wr_addr is ADDR_WIDTH+1 bits internally; mem_addr takes the low bits.
- rst mid-load: returns to IDLE immediately with reset values. Partially written RAM contents are not restored. Pending assembled bytes are discarded.
- Stalls: s_valid low for any number of cycles in HDR/DATA holds state; there is no timeout.

Decomposition:
- Shared defines file (alongside PC_WIDTH/INST_WIDTH): loader state encodings, LDR_HDR_BYTES=2, BYTES_PER_INST=4.
- One natural sub-module: ldr_word_assembler, holding the byte_idx counter, the 4-byte little-endian shift/insert register and the word_ready flag.
- The FSM, address counter and length check stay in inst_loader.
- The instruction RAM is instantiated at the top level and shared with fetch via a port mux selected by cpu_hold.

Test Plan:
- After reset: cpu_hold=1, done=0, mem_we=0. Then start, stream 02 00 | 13 00 00 00 | 6F 00 00 00 -> writes addr0=0x00000013 and addr1=0x0000006F. Each mem_we pulse is 1 cycle, one cycle after the 4th byte. Then done=1, cpu_hold=0, words_written=2.
- Same load with s_valid toggled randomly (50% duty) -> identical RAM contents. No byte lost or duplicated; s_ready=0 during every WRITE cycle.
- Header 00 00 -> DONE in the cycle after HDR1, no mem_we, done=1, words_written=0.
- ADDR_WIDTH=4 with header 11 00 (17 > 16) -> err_len=1, done=0, cpu_hold stays 1, zero writes. Next start with header 01 00 plus word -> err_len cleared, done=1.
- rst asserted after 1.5 words -> next cycle IDLE, s_ready=0, mem_we=0, cpu_hold=1, words_written=0. A fresh load after that writes from addr 0.
- Reload from DONE: start -> cpu_hold=1 in the same cycle; a new 1-word load overwrites addr0; start pulses while busy have no effect.
